// File: rtl/pump_pwm_if.sv
// Command/status bundle between the filter control FSM and the two-channel pump PWM block.
// The controller drives enable and duty commands; the PWM block returns drives and status.
interface pump_pwm_if;
    logic       enable;
    logic [7:0] pwm_duty_a;
    logic [7:0] pwm_duty_b;
    logic       pwm_out_a;
    logic       pwm_out_b;
    logic       period_start;
    logic [7:0] duty_active_a;
    logic [7:0] duty_active_b;

    modport master (
        output enable, pwm_duty_a, pwm_duty_b,
        input  pwm_out_a, pwm_out_b, period_start, duty_active_a, duty_active_b
    );

    modport slave (
        input  enable, pwm_duty_a, pwm_duty_b,
        output pwm_out_a, pwm_out_b, period_start, duty_active_a, duty_active_b
    );
endinterface

// File: rtl/pump_pwm.sv
// Two-channel, phase-aligned pump PWM with duty double-buffered at period boundaries.
// Define PUMP_PWM_RAMP_EN to slew-limit the applied duty by RAMP_STEP per period.
module pump_pwm #(
    parameter int unsigned PRESCALE  = 8,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    pump_pwm_if.slave   bus
);
    localparam int unsigned PWM_STEPS = 255;
    localparam logic [7:0]  CNT_MAX   = 8'(PWM_STEPS - 1);
    localparam logic [15:0] PRE_MAX   = 16'(PRESCALE - 1);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("pump_pwm: PRESCALE out of range 1..65535");
    end
    if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_ramp_step
        $error("pump_pwm: RAMP_STEP out of range 1..255");
    end

    logic [15:0] pre_cnt;
    logic [7:0]  cnt;
    logic        enable_q;
    logic [7:0]  duty_a_q;
    logic [7:0]  duty_b_q;
    logic        out_a_q;
    logic        out_b_q;
    logic        start_q;
    logic        tick;

    assign tick = (pre_cnt == PRE_MAX);

    // New applied duty at a boundary; with ramping it creeps toward the target.
    function automatic logic [7:0] next_duty(input logic [7:0] active, input logic [7:0] target);
`ifdef PUMP_PWM_RAMP_EN
        logic [8:0] a9;
        logic [8:0] t9;
        logic [8:0] s9;
        logic [8:0] d9;
        logic [8:0] r9;
        a9 = {1'b0, active};
        t9 = {1'b0, target};
        s9 = 9'(RAMP_STEP);
        d9 = 9'd0;
        r9 = a9;
        if (t9 > a9) begin
            d9 = t9 - a9;
            r9 = a9 + ((d9 < s9) ? d9 : s9);
        end else if (t9 < a9) begin
            d9 = a9 - t9;
            r9 = a9 - ((d9 < s9) ? d9 : s9);
        end
        return 8'(r9);
`else
        logic [7:0] unused_active;
        unused_active = active;
        return target;
`endif
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            cnt      <= '0;
            enable_q <= 1'b0;
            duty_a_q <= '0;
            duty_b_q <= '0;
            out_a_q  <= 1'b0;
            out_b_q  <= 1'b0;
            start_q  <= 1'b0;
        end else if (!bus.enable) begin
            pre_cnt  <= '0;
            cnt      <= '0;
            enable_q <= 1'b0;
            duty_a_q <= '0;
            duty_b_q <= '0;
            out_a_q  <= 1'b0;
            out_b_q  <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            enable_q <= 1'b1;
            out_a_q  <= (cnt < duty_a_q);
            out_b_q  <= (cnt < duty_b_q);
            start_q  <= 1'b0;
            if (!enable_q) begin
                // Re-enable edge is a period start, ramping from the zeroed duty.
                pre_cnt  <= '0;
                cnt      <= '0;
                duty_a_q <= next_duty(duty_a_q, bus.pwm_duty_a);
                duty_b_q <= next_duty(duty_b_q, bus.pwm_duty_b);
                start_q  <= 1'b1;
            end else if (tick) begin
                pre_cnt <= '0;
                if (cnt == CNT_MAX) begin
                    cnt      <= '0;
                    duty_a_q <= next_duty(duty_a_q, bus.pwm_duty_a);
                    duty_b_q <= next_duty(duty_b_q, bus.pwm_duty_b);
                    start_q  <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end

    assign bus.pwm_out_a     = out_a_q;
    assign bus.pwm_out_b     = out_b_q;
    assign bus.period_start  = start_q;
    assign bus.duty_active_a = duty_a_q;
    assign bus.duty_active_b = duty_b_q;
endmodule

// File: tb/tb_pump_pwm.sv
// Directed bench for pump_pwm at PRESCALE=2 (510-clk period); outputs sampled on falling edges.
// Build with PUMP_PWM_RAMP_EN defined to exercise the slew-limited variant.
module tb_pump_pwm;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pump_pwm_if bus ();

    pump_pwm #(.PRESCALE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Counts high samples of each output and period pulses over n falling edges.
    task automatic measure(input int n, output int ha, output int hb, output int ps);
        ha = 0;
        hb = 0;
        ps = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ha += int'(bus.pwm_out_a);
            hb += int'(bus.pwm_out_b);
            ps += int'(bus.period_start);
        end
    endtask

    // Leaves the bench at the falling edge right after the re-enable (period start) edge.
    task automatic start_pwm(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.enable     = 1'b0;
        bus.pwm_duty_a = a;
        bus.pwm_duty_b = b;
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp_first;
`ifdef PUMP_PWM_RAMP_EN
        exp_first = 8'd4;
`else
        exp_first = 8'd200;
`endif
        reset          = 1'b0;
        bus.enable     = 1'b1;
        bus.pwm_duty_a = 8'd200;
        bus.pwm_duty_b = 8'd200;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pwm_out_a, bus.pwm_out_b, bus.period_start} !== 3'b000 ||
            bus.duty_active_a !== 8'd0 || bus.duty_active_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold: outs=%b%b ps=%b da=%0d db=%0d required all 0",
                     bus.pwm_out_a, bus.pwm_out_b, bus.period_start, bus.duty_active_a, bus.duty_active_b);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.period_start !== 1'b1 || bus.duty_active_a !== exp_first) begin
            failures++;
            $display("FAIL reset_first_start: ps=%b da=%0d required ps=1 da=%0d",
                     bus.period_start, bus.duty_active_a, exp_first);
        end
        @(negedge clk);
        checks++;
        if (bus.period_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulse_width: ps=%b required 0", bus.period_start);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.pwm_out_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_high: out_a=%b required 1", bus.pwm_out_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.pwm_out_a !== 1'b0 || bus.duty_active_a !== 8'd0 || bus.duty_active_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_async: out_a=%b da=%0d db=%0d required 0 0 0",
                     bus.pwm_out_a, bus.duty_active_a, bus.duty_active_b);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

`ifdef PUMP_PWM_RAMP_EN
    task automatic test_ramp();
        int ha, hb, ps;
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'd8;
        exp_seq[1] = 8'd10;
        exp_seq[2] = 8'd6;
        exp_seq[3] = 8'd3;
        start_pwm(8'd10, 8'd0);
        checks++;
        if (bus.duty_active_a !== 8'd4 || bus.duty_active_b !== 8'd0) begin
            failures++;
            $display("FAIL ramp_first: da=%0d db=%0d required 4 0", bus.duty_active_a, bus.duty_active_b);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.pwm_duty_a = 8'd3;
            measure(510, ha, hb, ps);
            checks++;
            if (bus.duty_active_a !== exp_seq[k] || ps !== 1) begin
                failures++;
                $display("FAIL ramp_step%0d: da=%0d pulses=%0d required da=%0d pulses=1",
                         k, bus.duty_active_a, ps, exp_seq[k]);
            end
        end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.duty_active_a !== 8'd0) begin
            failures++;
            $display("FAIL ramp_disable_zero: da=%0d required 0", bus.duty_active_a);
        end
    endtask
`else
    task automatic test_duty_accuracy();
        int ha, hb, ps;
        start_pwm(8'd128, 8'd0);
        checks++;
        if (bus.period_start !== 1'b1 || bus.duty_active_a !== 8'd128) begin
            failures++;
            $display("FAIL acc_start: ps=%b da=%0d required 1 128", bus.period_start, bus.duty_active_a);
        end
        for (int k = 0; k < 2; k++) begin
            measure(510, ha, hb, ps);
            checks++;
            if (ha !== 256 || hb !== 0 || ps !== 1) begin
                failures++;
                $display("FAIL acc_period%0d: high_a=%0d high_b=%0d pulses=%0d required 256 0 1", k, ha, hb, ps);
            end
        end
    endtask

    task automatic test_extremes();
        int ha, hb, ps;
        start_pwm(8'd255, 8'd1);
        for (int k = 0; k < 2; k++) begin
            measure(510, ha, hb, ps);
            checks++;
            if (ha !== 510 || hb !== 2 || ps !== 1) begin
                failures++;
                $display("FAIL ext_period%0d: high_a=%0d high_b=%0d pulses=%0d required 510 2 1", k, ha, hb, ps);
            end
        end
    endtask

    task automatic test_double_buffer();
        int ha1, ha2, hb, ps;
        start_pwm(8'd50, 8'd0);
        measure(200, ha1, hb, ps);
        bus.pwm_duty_a = 8'd180;
        @(negedge clk);
        checks++;
        if (bus.duty_active_a !== 8'd50) begin
            failures++;
            $display("FAIL dbuf_mid_hold: da=%0d required 50", bus.duty_active_a);
        end
        measure(309, ha2, hb, ps);
        checks++;
        if (ha1 + ha2 + 0 !== 100 || ps !== 1 || bus.duty_active_a !== 8'd180) begin
            failures++;
            $display("FAIL dbuf_period0: high_a=%0d pulses=%0d da=%0d required 100 1 180",
                     ha1 + ha2, ps, bus.duty_active_a);
        end
        measure(510, ha1, hb, ps);
        checks++;
        if (ha1 !== 360) begin
            failures++;
            $display("FAIL dbuf_period1: high_a=%0d required 360", ha1);
        end
    endtask

    task automatic test_enable_drop();
        int ha, hb, ps;
        start_pwm(8'd200, 8'd100);
        measure(50, ha, hb, ps);
        checks++;
        if (bus.pwm_out_a !== 1'b1 || bus.pwm_out_b !== 1'b1) begin
            failures++;
            $display("FAIL drop_pre_high: outs=%b%b required 11", bus.pwm_out_a, bus.pwm_out_b);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pwm_out_a !== 1'b0 || bus.pwm_out_b !== 1'b0 || bus.period_start !== 1'b0 ||
            bus.duty_active_a !== 8'd0 || bus.duty_active_b !== 8'd0) begin
            failures++;
            $display("FAIL drop_zero: outs=%b%b ps=%b da=%0d db=%0d required all 0",
                     bus.pwm_out_a, bus.pwm_out_b, bus.period_start, bus.duty_active_a, bus.duty_active_b);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.period_start !== 1'b1 || bus.duty_active_a !== 8'd200 || bus.duty_active_b !== 8'd100) begin
            failures++;
            $display("FAIL drop_reassert: ps=%b da=%0d db=%0d required 1 200 100",
                     bus.period_start, bus.duty_active_a, bus.duty_active_b);
        end
        measure(510, ha, hb, ps);
        checks++;
        if (ha !== 400 || hb !== 200 || ps !== 1) begin
            failures++;
            $display("FAIL drop_restart_period: high_a=%0d high_b=%0d pulses=%0d required 400 200 1", ha, hb, ps);
        end
        measure(509, ha, hb, ps);
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.period_start !== 1'b0 || bus.duty_active_a !== 8'd0) begin
            failures++;
            $display("FAIL drop_on_boundary: ps=%b da=%0d required 0 0", bus.period_start, bus.duty_active_a);
        end
        measure(20, ha, hb, ps);
        checks++;
        if (ha !== 0 || hb !== 0 || ps !== 0) begin
            failures++;
            $display("FAIL drop_idle: high_a=%0d high_b=%0d pulses=%0d required 0 0 0", ha, hb, ps);
        end
    endtask
`endif

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.enable     = 1'b0;
        bus.pwm_duty_a = 8'd0;
        bus.pwm_duty_b = 8'd0;
        test_reset();
`ifdef PUMP_PWM_RAMP_EN
        test_ramp();
`else
        test_duty_accuracy();
        test_extremes();
        test_double_buffer();
        test_enable_drop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pump_pwm.md
Name: pump_pwm

Overview:
- Two-channel PWM generator driving pump A and pump B power stages.
- Consumes the 8-bit duty commands pwm_duty_a / pwm_duty_b produced by the filter control FSM.
- Duty is double-buffered: new commands take effect only at a PWM period boundary, so no period is truncated.
- Optional slew limiting.

Parameters:
- PRESCALE, 8: clk cycles per PWM step. 50 MHz / 8 / 255 ≈ 24.5 kHz PWM. Legal range 1..65535.
- PWM_STEPS, 255: steps per period; fixed value, not overridable.
- RAMP_STEP, 4: maximum change of active duty per period. Used only with PUMP_PWM_RAMP_EN. Legal range 1..255.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- enable  input  1  1 = generate PWM; 0 = force pumps off.
- pwm_duty_a  input  8  commanded duty, channel A (0 = off, 255 = 100 %).
- pwm_duty_b  input  8  commanded duty, channel B.
- pwm_out_a  output  1  registered PWM drive, pump A.
- pwm_out_b  output  1  registered PWM drive, pump B.
- period_start  output  1  one-clk pulse in the cycle step counter is 0 after a boundary.
- duty_active_a  output  8  duty currently applied, channel A.
- duty_active_b  output  8  duty currently applied, channel B.

Behaviour:
- Reset (reset=0, asynchronous) clears all registers to 0: prescaler, step counter, enable_q, duty_active_a/b, pwm_out_a/b, period_start.
- Prescaler pre_cnt:
  - Counts 0..PRESCALE-1 while enable=1.
  - tick = (pre_cnt==PRESCALE-1).
  - Wraps to 0 on tick.
- Step counter cnt:
  - 8 bits, 0..254.
  - Advances on tick.
  - On tick with cnt==254 it wraps to 0. This is a period boundary.
- Period boundary actions, same clk edge as the cnt wrap:
  - Sample pwm_duty_a/b into duty_active_a/b.
  - Raise period_start for exactly 1 clk.
  - Duty inputs are ignored at all other times; mid-period changes have no effect until the next boundary.
- Output generation, registered:
  - pwm_out_x <= enable & (cnt < duty_active_x), evaluated on current register values.
  - Output therefore lags cnt by 1 clk, identically on both channels.
- Duty edge cases:
  - Duty 0: output never high.
  - Duty 255: always high, since cnt max 254 < 255.
  - Duty D: high for exactly D*PRESCALE clks of every 255*PRESCALE-clk period.
- Enable deassert:
  - At the first edge where enable=0: pre_cnt, cnt and duty_active_a/b go to 0.
  - pwm_out_a/b go to 0 at that same edge.
  - period_start is 0.
- Enable re-assert:
  - The first edge with enable=1 and enable_q=0 is a period start.
  - At that edge: cnt=0, pre_cnt=0, duty inputs are sampled (or ramped from 0), and period_start pulses.
- Simultaneous enable=0 and boundary: enable=0 wins; no sample, no pulse.
- Reset mid-period: immediate clear; the first period after release starts only when the enable re-assert rule fires. enable_q is 0 after reset.
- Both channels share one counter and are phase-aligned; no dead time is inserted.

Optional Feature:
- Macro: PUMP_PWM_RAMP_EN.
- Defined: at each boundary, duty_active_x moves toward the sampled target by at most RAMP_STEP.
  - Computed in 9-bit unsigned arithmetic.
  - If target > active: active += min(RAMP_STEP, target-active).
  - If target < active: active -= min(RAMP_STEP, active-target).
  - No overflow or underflow past the target.
  - The enable re-assert edge counts as a boundary and ramps from 0.
  - Enable=0 still zeroes instantly; there is no ramp-down.
- Undefined: duty_active_x = sampled target at each boundary; RAMP_STEP unused.

Test Plan:
- Reset: hold reset=0 with enable=1, duties 200 -> all outputs 0; after release, period_start pulses on the first enabled edge and duty_active_a=200.
- Duty accuracy: PRESCALE=2, enable=1, duty_a=128, duty_b=0 -> pwm_out_a high 256 clks of every 510, pwm_out_b always 0, period_start every 510 clks.
- Extremes: duty_a=255, duty_b=1 with PRESCALE=2 -> pwm_out_a continuously 1 across boundaries; pwm_out_b high exactly 2 clks per period.
- Double-buffering: change duty_a 50->180 at cnt=100 -> current period stays at 50 (100 clks high at PRESCALE=2); the next period is 180 (360 clks high).
- Enable drop: deassert enable mid-high-phase -> pwm_out_a/b 0 at that edge, duty_active 0. Re-assert -> period_start on the first edge and cnt restarts at 0. Drop enable on a boundary edge -> no period_start pulse.
- Ramp (PUMP_PWM_RAMP_EN, RAMP_STEP=4): target 0->10 -> duty_active_a 4, 8, 10 over three boundaries. Then target 10->3 -> 6, 3.
